axis_rr_packet_arbiter: RTL and testbench

//  Shares one downstream AXI4-Stream among S_COUNT upstream requesters with packet-granular round-robin.
//  A grant is held from the first beat to the accepted tlast beat, so packets never interleave.

---
 rtl/axis_rr_packet_arbiter_pkg.sv | 33 +++
 rtl/axis_rr_packet_arbiter_reg.sv | 51 +++++
 rtl/axis_rr_packet_arbiter.sv | 120 ++++++++++++
 tb/tb_axis_rr_packet_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rr_packet_arbiter_pkg.sv
// Shared types and the round-robin selection helper for the packet arbiter.
package axis_rr_packet_arbiter_pkg;

    // Arbiter FSM encoding
    typedef logic [0:0] state_t;
    localparam state_t IDLE   = 1'b0;
    localparam state_t ACTIVE = 1'b1;

    // Upper bound on the number of requesters the helper can search
    localparam int MAX_S = 32;

    typedef logic [MAX_S-1:0] req_t;
    typedef logic [4:0]       idx_t;

    // First set bit of req searching upward from ptr+1, wrapping modulo n.
    // Returns ptr unchanged when no request is set.
    function automatic idx_t rr_select(input req_t req, input idx_t ptr, input int n);
        idx_t sel;
        logic found;
        int   idx;
        sel   = ptr;
        found = 1'b0;
        for (int i = 1; i <= MAX_S; i++) begin
            idx = (int'(ptr) + i) % n;
            if (i <= n && !found && req[idx_t'(idx)]) begin
                sel   = idx_t'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/axis_rr_packet_arbiter_reg.sv
// Two-entry skid register: full throughput, registered valid/data and registered ready.
module axis_rr_packet_arbiter_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] skid_q;
    logic             out_vld_q;
    logic             skid_vld_q;

    // Ready depends only on skid occupancy, so upstream sees stalls one cycle late
    assign s_ready = ~skid_vld_q;
    assign m_data  = out_q;
    assign m_valid = out_vld_q;

    // Occupancy flags: output slot refills from skid first, else from the input
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (m_ready || !out_vld_q) begin
            if (skid_vld_q) begin
                out_vld_q  <= 1'b1;
                skid_vld_q <= 1'b0;
            end else begin
                out_vld_q <= s_valid;
            end
        end else if (s_valid && !skid_vld_q) begin
            skid_vld_q <= 1'b1;
        end
    end

    // Payload moves alongside the flags; no reset needed on data
    always_ff @(posedge clk) begin
        if (m_ready || !out_vld_q) begin
            out_q <= skid_vld_q ? skid_q : s_data;
        end else if (s_valid && !skid_vld_q) begin
            skid_q <= s_data;
        end
    end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream among S_COUNT sources.
module axis_rr_packet_arbiter
    import axis_rr_packet_arbiter_pkg::*;
#(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int LAST_ENABLE = 1,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    localparam int CL_S       = $clog2(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [CL_S-1:0]               m_axis_tid,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          busy,
    output logic [CL_S-1:0]               grant_index
);

    localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + CL_S + USER_WIDTH;

    state_t          state_q;
    logic [CL_S-1:0] grant_q;
    logic [CL_S-1:0] rr_ptr_q;
    logic [CL_S-1:0] next_sel;

    logic [DATA_WIDTH-1:0] mux_data;
    logic [KEEP_WIDTH-1:0] mux_keep;
    logic                  mux_last;
    logic [USER_WIDTH-1:0] mux_user;
    logic                  mux_valid;
    logic                  reg_s_ready;
    logic [PW-1:0]         reg_in;
    logic [PW-1:0]         reg_out;

    assign next_sel    = CL_S'(rr_select(req_t'(s_axis_tvalid), idx_t'(rr_ptr_q), S_COUNT));
    assign busy        = (state_q == ACTIVE);
    assign grant_index = grant_q;

    // Input mux onto the granted stream; only the grantee ever sees ready
    always_comb begin
        mux_data      = '0;
        mux_keep      = '1;
        mux_last      = 1'b0;
        mux_user      = '0;
        mux_valid     = 1'b0;
        s_axis_tready = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_q == CL_S'(i)) begin
                mux_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                // Disabled sidebands collapse to all-ones keep, forced last, zero user
                mux_keep = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH]
                           | {KEEP_WIDTH{KEEP_ENABLE == 0}};
                mux_last = s_axis_tlast[i] | (LAST_ENABLE == 0);
                mux_user = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH]
                           & {USER_WIDTH{USER_ENABLE != 0}};
                if (state_q == ACTIVE) begin
                    mux_valid        = s_axis_tvalid[i];
                    s_axis_tready[i] = reg_s_ready;
                end
            end
        end
    end

    // Arbitrate in IDLE, hold the grant until the closing beat is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= CL_S'(S_COUNT - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant_q  <= next_sel;
                        rr_ptr_q <= next_sel;
                        state_q  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (mux_valid && reg_s_ready && mux_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The grant index rides with each beat as its tid
    assign reg_in = {mux_data, mux_keep, mux_last, grant_q, mux_user};
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tuser} = reg_out;

    axis_rr_packet_arbiter_reg #(
        .WIDTH(PW)
    ) u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .s_data (reg_in),
        .s_valid(mux_valid),
        .s_ready(reg_s_ready),
        .m_data (reg_out),
        .m_valid(m_axis_tvalid),
        .m_ready(m_axis_tready)
    );

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Scoreboard bench: per-source FIFO order model, packet non-interleave, grant order and timing.
module tb_axis_rr_packet_arbiter;

    localparam int S  = 4;
    localparam int DW = 8;
    localparam int KW = 1;
    localparam int UW = 1;
    localparam int CL = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        beat_t b;
        int    gap;
    } src_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [S*DW-1:0] s_data;
    logic [S*KW-1:0] s_keep;
    logic [S-1:0]    s_valid;
    logic [S-1:0]    s_ready;
    logic [S-1:0]    s_last;
    logic [S*UW-1:0] s_user;
    logic [DW-1:0]   m_data;
    logic [KW-1:0]   m_keep;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;
    logic [CL-1:0]   m_tid;
    logic [UW-1:0]   m_user;
    logic            busy;
    logic [CL-1:0]   grant_index;

    // Second instance with per-beat arbitration
    logic [S*DW-1:0] nl_s_data;
    logic [S-1:0]    nl_s_valid;
    logic [S-1:0]    nl_s_ready;
    logic [DW-1:0]   nl_m_data;
    logic [KW-1:0]   nl_m_keep;
    logic            nl_m_valid;
    logic            nl_m_ready;
    logic            nl_m_last;
    logic [CL-1:0]   nl_m_tid;
    logic [UW-1:0]   nl_m_user;
    logic            nl_busy;
    logic [CL-1:0]   nl_grant;

    axis_rr_packet_arbiter #(
        .S_COUNT(S), .DATA_WIDTH(DW), .LAST_ENABLE(1), .USER_ENABLE(1), .USER_WIDTH(UW)
    ) u_dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
        .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready), .m_axis_tlast(m_last), .m_axis_tid(m_tid),
        .m_axis_tuser(m_user), .busy(busy), .grant_index(grant_index)
    );

    axis_rr_packet_arbiter #(
        .S_COUNT(S), .DATA_WIDTH(DW), .LAST_ENABLE(0), .USER_ENABLE(1), .USER_WIDTH(UW)
    ) u_dut_nl (
        .clk(clk), .rst(rst),
        .s_axis_tdata(nl_s_data), .s_axis_tkeep({S{1'b1}}), .s_axis_tvalid(nl_s_valid),
        .s_axis_tready(nl_s_ready), .s_axis_tlast({S{1'b0}}), .s_axis_tuser({S{1'b0}}),
        .m_axis_tdata(nl_m_data), .m_axis_tkeep(nl_m_keep), .m_axis_tvalid(nl_m_valid),
        .m_axis_tready(nl_m_ready), .m_axis_tlast(nl_m_last), .m_axis_tid(nl_m_tid),
        .m_axis_tuser(nl_m_user), .busy(nl_busy), .grant_index(nl_grant)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int onehot_err = 0;

    src_t  src_q[S][$];
    beat_t exp_q[S][$];
    logic  loaded[S];
    int    gap_left[S];
    logic [S-1:0] fire;
    logic  rand_ready = 1'b0;

    int   log_tid[$];
    int   log_cyc[$];
    logic log_last[$];
    int   nl_tid[$];
    int   nl_cyc[$];

    logic in_pkt = 1'b0;
    int   cur_tid = 0;
    int   mon_t;
    beat_t mon_exp;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Input handshakes for the coming edge, sampled mid-cycle
    always @(negedge clk) fire = s_valid & s_ready;

    // Output monitor: pop the per-source model queue on every accepted output beat
    always @(negedge clk) begin
        if (rst) begin
            in_pkt = 1'b0;
        end else begin
            if ($countones(s_ready) > 1) onehot_err++;
            if (m_valid && m_ready) begin
                mon_t = int'(m_tid);
                log_tid.push_back(mon_t);
                log_cyc.push_back(cyc);
                log_last.push_back(m_last);
                check("tkeep", 32'(m_keep), 32'h1);
                if (in_pkt) check("no_interleave", mon_t, cur_tid);
                if (exp_q[mon_t].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: got beat tid=%0d data=%0h, expected none", mon_t,
                             m_data);
                end else begin
                    mon_exp = exp_q[mon_t].pop_front();
                    check("sb_beat", {m_data, m_last, m_user}, mon_exp);
                end
                cur_tid = mon_t;
                in_pkt  = !m_last;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && nl_m_valid && nl_m_ready) begin
            nl_tid.push_back(int'(nl_m_tid));
            nl_cyc.push_back(cyc);
        end
    end

    task automatic push_beat(input int s, input logic [7:0] d, input logic l, input logic u,
                             input int g);
        src_t e;
        e.b.data = d;
        e.b.last = l;
        e.b.user = u;
        e.gap    = g;
        src_q[s].push_back(e);
        exp_q[s].push_back(e.b);
    endtask

    task automatic push_pkt(input int s, input int len, input logic rand_gaps);
        int g;
        for (int k = 0; k < len; k++) begin
            g = (rand_gaps && ($urandom % 4 == 0)) ? int'($urandom % 3) : 0;
            push_beat(s, 8'($urandom), k == len - 1, 1'($urandom), g);
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < S; i++) n += exp_q[i].size() + src_q[i].size();
        return n;
    endfunction

    task automatic flush();
        for (int i = 0; i < S; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            loaded[i] = 1'b0;
        end
        s_valid = '0;
    endtask

    // One clock: retire accepted beats, then present the next head of each source
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < S; i++) begin
            if (fire[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
                loaded[i] = 1'b0;
            end
        end
        m_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
        for (int i = 0; i < S; i++) begin
            if (src_q[i].size() == 0) begin
                s_valid[i] = 1'b0;
            end else begin
                if (!loaded[i]) begin
                    gap_left[i] = src_q[i][0].gap;
                    loaded[i]   = 1'b1;
                end
                if (gap_left[i] > 0) begin
                    s_valid[i] = 1'b0;
                    gap_left[i]--;
                end else begin
                    s_valid[i]           = 1'b1;
                    s_data[i*DW +: DW]   = src_q[i][0].b.data;
                    s_last[i]            = src_q[i][0].b.last;
                    s_user[i*UW +: UW]   = src_q[i][0].b.user;
                end
            end
        end
    endtask

    task automatic run_until_empty(input string name, input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drained"}, pending(), 0);
        repeat (3) tick();
    endtask

    task automatic clear_log();
        log_tid.delete();
        log_cyc.delete();
        log_last.delete();
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int c0;
        s_data = '0; s_keep = '1; s_valid = '0; s_last = '0; s_user = '0; m_ready = 1'b1;
        nl_s_data = '0; nl_s_valid = '0; nl_m_ready = 1'b1;
        for (int i = 0; i < S; i++) begin
            loaded[i] = 1'b0;
            gap_left[i] = 0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_index, 0);
        tick();
        rst = 1'b0;
        tick();

        // All four sources with two 2-beat packets each: strict rotation from stream 0
        clear_log();
        for (int r = 0; r < 2; r++) for (int s = 0; s < S; s++) push_pkt(s, 2, 1'b0);
        run_until_empty("t2", 200);
        check("t2_count", log_tid.size(), 16);
        if (log_tid.size() == 16) begin
            for (int k = 0; k < 8; k++) begin
                check("t2_order", log_tid[2*k], k % S);
                check("t2_pair_tid", log_tid[2*k+1], k % S);
                check("t2_pair_b2b", log_cyc[2*k+1] - log_cyc[2*k], 1);
                if (k < 7) check("t2_bubble", log_cyc[2*k+2] - log_cyc[2*k+1], 2);
            end
        end

        // Lone stream 2 three-beat packet: latency 2, consecutive beats, tlast on C
        clear_log();
        push_beat(2, 8'hA1, 1'b0, 1'b0, 0);
        push_beat(2, 8'hB2, 1'b0, 1'b1, 0);
        push_beat(2, 8'hC3, 1'b1, 1'b0, 0);
        tick();
        c0 = cyc;
        @(negedge clk);
        check("t1_busy_in_idle", busy, 0);
        run_until_empty("t1", 100);
        check("t1_count", log_tid.size(), 3);
        if (log_tid.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                check("t1_tid", log_tid[k], 2);
                check("t1_cycle", log_cyc[k], c0 + 2 + k);
                check("t1_last", log_last[k], k == 2);
            end
        end

        // Stream 1 stalls mid-packet while stream 3 waits
        clear_log();
        push_beat(1, 8'h10, 1'b0, 1'b0, 0);
        push_beat(1, 8'h11, 1'b0, 1'b0, 0);
        push_beat(1, 8'h12, 1'b0, 1'b0, 3);
        push_beat(1, 8'h13, 1'b1, 1'b0, 0);
        tick();
        tick();
        push_pkt(3, 2, 1'b0);
        run_until_empty("t3", 200);
        check("t3_count", log_tid.size(), 6);
        if (log_tid.size() == 6) begin
            for (int k = 0; k < 6; k++) check("t3_order", log_tid[k], (k < 4) ? 1 : 3);
        end

        // 1000 random packets with random output backpressure and input gaps
        clear_log();
        rand_ready = 1'b1;
        for (int p = 0; p < 1000; p++) push_pkt(int'($urandom % S), 1 + int'($urandom % 4), 1'b1);
        run_until_empty("t4", 40000);
        rand_ready = 1'b0;
        repeat (3) tick();
        begin
            int nlast = 0;
            foreach (log_last[k]) nlast += int'(log_last[k]);
            check("t4_packets", nlast, 1000);
        end
        check("t4_ready_onehot", onehot_err, 0);

        // Reset during beat 2 of 4
        push_pkt(0, 4, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        flush();
        @(negedge clk);
        check("t5_m_valid", m_valid, 0);
        check("t5_s_ready", s_ready, 0);
        check("t5_busy", busy, 0);
        check("t5_grant", grant_index, 0);
        clear_log();
        push_pkt(2, 1, 1'b0);
        push_pkt(0, 1, 1'b0);
        run_until_empty("t5", 100);
        check("t5_count", log_tid.size(), 2);
        if (log_tid.size() == 2) check("t5_first_grant", log_tid[0], 0);

        // Per-beat arbitration: streams 0 and 1 always valid
        nl_tid.delete();
        nl_cyc.delete();
        nl_s_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        nl_s_valid = 4'b0011;
        repeat (14) tick();
        nl_s_valid = '0;
        repeat (3) tick();
        check("t6_count", nl_tid.size() >= 5, 1);
        if (nl_tid.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check("t6_tid", nl_tid[k], k % 2);
                if (k > 0) check("t6_bubble", nl_cyc[k] - nl_cyc[k-1], 2);
            end
        end

        check("final_pending", pending(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
